// File: rtl/aurora_64b66b_tx.sv
// aurora_64b66b_tx
// Turns local EDS-end / PMT-end event strobes into two-beat AXI-Stream
// frames for the Aurora 64B/66B TX user interface (USER_CLK domain).
// Beat 0 carries {frame count, header word}; beat 1 carries the end code.
// Transmission is gated on a debounced CHANNEL_UP.
module aurora_64b66b_tx #(
    parameter real         TCQ       = 0.1,
    parameter logic [31:0] HEAD_WORD = 32'h55aa_0001,
    parameter logic [7:0]  EDS_CODE  = 8'd1,
    parameter logic [7:0]  PMT_CODE  = 8'd2
) (
    input  logic        USER_CLK,
    input  logic        RESET,
    input  logic        CHANNEL_UP,
    input  logic        eds_end_i,
    input  logic        pmt_end_i,
    input  logic        tx_tready_i,
    output logic        tx_tvalid_o,
    output logic [63:0] tx_tdata_o,
    output logic [7:0]  tx_tkeep_o,
    output logic        tx_tlast_o,
    output logic [31:0] frame_cnt_o,
    output logic [15:0] merge_cnt_o,
    output logic        link_ready_o
);

    // TCQ models clock-to-q delay for simulation wrappers; the
    // registers here carry no explicit delay.

    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_HEAD = 2'd1;
    localparam logic [1:0] TX_CODE = 2'd2;

    logic [4:0]  link_cnt_q,  link_cnt_d;
    logic        eds_prev_q,  eds_prev_d;
    logic        pmt_prev_q,  pmt_prev_d;
    logic        eds_pend_q,  eds_pend_d;
    logic        pmt_pend_q,  pmt_pend_d;
    logic [1:0]  state_q,     state_d;
    logic [7:0]  code_q,      code_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] merge_cnt_q, merge_cnt_d;

    logic        link_ready;
    logic        eds_edge, pmt_edge;
    logic        eds_take, pmt_take;
    logic        eds_merge, pmt_merge;
    logic [1:0]  merge_inc;
    logic [16:0] merge_sum;

    assign link_ready = link_cnt_q[4];

    // Link debounce: count CHANNEL_UP cycles, saturate once bit 4 is set.
    always_comb begin
        link_cnt_d = link_cnt_q;
        if (!CHANNEL_UP) begin
            link_cnt_d = 5'd0;
        end else if (!link_cnt_q[4]) begin
            link_cnt_d = link_cnt_q + 5'd1;
        end
    end

    // Frame FSM: pick a pending request (EDS first), send head then code.
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        frame_cnt_d = frame_cnt_q;
        eds_take    = 1'b0;
        pmt_take    = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (link_ready && (eds_pend_q || pmt_pend_q)) begin
                    state_d = TX_HEAD;
                    if (eds_pend_q) begin
                        code_d   = EDS_CODE;
                        eds_take = 1'b1;
                    end else begin
                        code_d   = PMT_CODE;
                        pmt_take = 1'b1;
                    end
                end
            end
            TX_HEAD: begin
                if (!link_ready) begin
                    state_d = TX_IDLE;
                end else if (tx_tready_i) begin
                    state_d = TX_CODE;
                end
            end
            TX_CODE: begin
                // A link drop aborts the frame even if tready is high.
                if (!link_ready) begin
                    state_d = TX_IDLE;
                end else if (tx_tready_i) begin
                    state_d     = TX_IDLE;
                    frame_cnt_d = frame_cnt_q + 32'd1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Event capture: rising edges set pending flags; repeats while pending merge.
    always_comb begin
        eds_prev_d = eds_end_i;
        pmt_prev_d = pmt_end_i;
        eds_edge   = eds_end_i & ~eds_prev_q;
        pmt_edge   = pmt_end_i & ~pmt_prev_q;
        // A flag being taken this cycle is gone, so a coincident edge re-queues.
        eds_merge  = link_ready & eds_edge & eds_pend_q & ~eds_take;
        pmt_merge  = link_ready & pmt_edge & pmt_pend_q & ~pmt_take;
        eds_pend_d = link_ready & ((eds_pend_q & ~eds_take) | eds_edge);
        pmt_pend_d = link_ready & ((pmt_pend_q & ~pmt_take) | pmt_edge);
        merge_inc  = {1'b0, eds_merge} + {1'b0, pmt_merge};
        merge_sum  = {1'b0, merge_cnt_q} + {15'd0, merge_inc};
        merge_cnt_d = merge_sum[16] ? 16'hFFFF : merge_sum[15:0];
    end

    // State registers with asynchronous reset.
    always_ff @(posedge USER_CLK or posedge RESET) begin
        if (RESET) begin
            link_cnt_q  <= 5'd0;
            eds_prev_q  <= 1'b0;
            pmt_prev_q  <= 1'b0;
            eds_pend_q  <= 1'b0;
            pmt_pend_q  <= 1'b0;
            state_q     <= TX_IDLE;
            code_q      <= 8'd0;
            frame_cnt_q <= 32'd0;
            merge_cnt_q <= 16'd0;
        end else begin
            link_cnt_q  <= link_cnt_d;
            eds_prev_q  <= eds_prev_d;
            pmt_prev_q  <= pmt_prev_d;
            eds_pend_q  <= eds_pend_d;
            pmt_pend_q  <= pmt_pend_d;
            state_q     <= state_d;
            code_q      <= code_d;
            frame_cnt_q <= frame_cnt_d;
            merge_cnt_q <= merge_cnt_d;
        end
    end

    // AXI-Stream outputs decoded from state; zero outside a frame.
    always_comb begin
        tx_tvalid_o = 1'b0;
        tx_tdata_o  = 64'd0;
        tx_tkeep_o  = 8'h00;
        tx_tlast_o  = 1'b0;
        case (state_q)
            TX_HEAD: begin
                tx_tvalid_o = 1'b1;
                tx_tdata_o  = {frame_cnt_q, HEAD_WORD};
                tx_tkeep_o  = 8'hFF;
            end
            TX_CODE: begin
                tx_tvalid_o = 1'b1;
                tx_tdata_o  = {56'd0, code_q};
                tx_tkeep_o  = 8'hFF;
                tx_tlast_o  = 1'b1;
            end
            default: ;
        endcase
    end

    assign frame_cnt_o  = frame_cnt_q;
    assign merge_cnt_o  = merge_cnt_q;
    assign link_ready_o = link_ready;

endmodule

// File: tb/tb_aurora_64b66b_tx.sv
// Testbench for aurora_64b66b_tx: directed scenarios plus randomized
// traffic compared cycle by cycle against a request/beat level model.
module tb_aurora_64b66b_tx;

    localparam logic [31:0] HEAD = 32'h55aa_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cu = 1'b0;
    logic        eds = 1'b0;
    logic        pmt = 1'b0;
    logic        trdy = 1'b0;
    logic        tvalid;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic [31:0] frame_cnt;
    logic [15:0] merge_cnt;
    logic        link_ready;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: link-up cycle count, waiting requests, current beat
    int          m_up;
    bit          m_eds_w, m_pmt_w;
    int          m_beat;        // 0 = no frame, 1 = header beat, 2 = code beat
    logic [7:0]  m_code;
    logic [31:0] m_frames;
    int          m_merges;
    bit          m_prev_eds, m_prev_pmt;

    always #5 clk = ~clk;

    aurora_64b66b_tx dut (
        .USER_CLK     (clk),
        .RESET        (rst),
        .CHANNEL_UP   (cu),
        .eds_end_i    (eds),
        .pmt_end_i    (pmt),
        .tx_tready_i  (trdy),
        .tx_tvalid_o  (tvalid),
        .tx_tdata_o   (tdata),
        .tx_tkeep_o   (tkeep),
        .tx_tlast_o   (tlast),
        .frame_cnt_o  (frame_cnt),
        .merge_cnt_o  (merge_cnt),
        .link_ready_o (link_ready)
    );

    task automatic model_reset();
        m_up = 0; m_eds_w = 0; m_pmt_w = 0; m_beat = 0; m_code = 8'd0;
        m_frames = 32'd0; m_merges = 0; m_prev_eds = 0; m_prev_pmt = 0;
    endtask

    // Advance the model by one clock using the inputs presented before the edge.
    task automatic model_step();
        bit lr, e_edge, p_edge, e_take, p_take;
        lr = (m_up >= 16);
        e_edge = eds && !m_prev_eds;
        p_edge = pmt && !m_prev_pmt;
        e_take = 0; p_take = 0;
        if (m_beat == 0) begin
            if (lr && (m_eds_w || m_pmt_w)) begin
                m_beat = 1;
                if (m_eds_w) begin m_code = 8'd1; e_take = 1; end
                else begin m_code = 8'd2; p_take = 1; end
            end
        end else if (!lr) begin
            m_beat = 0;
        end else if (trdy) begin
            if (m_beat == 1) m_beat = 2;
            else begin m_beat = 0; m_frames = m_frames + 32'd1; end
        end
        if (lr) begin
            if (e_edge && m_eds_w && !e_take && m_merges < 65535) m_merges++;
            if (p_edge && m_pmt_w && !p_take && m_merges < 65535) m_merges++;
            m_eds_w = (m_eds_w && !e_take) || e_edge;
            m_pmt_w = (m_pmt_w && !p_take) || p_edge;
        end else begin
            m_eds_w = 0; m_pmt_w = 0;
        end
        m_up = cu ? ((m_up < 16) ? m_up + 1 : 16) : 0;
        m_prev_eds = eds;
        m_prev_pmt = pmt;
    endtask

    // One clock: step the model, then settle just after the rising edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cu = 0; eds = 0; pmt = 0; trdy = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic link_up();
        cu = 1'b1;
        repeat (20) tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({tvalid, tdata, tkeep, tlast, frame_cnt, merge_cnt, link_ready} !== 123'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%0b data=%h keep=%h last=%0b frames=%0d merges=%0d link=%0b, need all zero",
                     tvalid, tdata, tkeep, tlast, frame_cnt, merge_cnt, link_ready);
        end
    endtask

    task automatic test_eds_frame();
        do_reset();
        link_up();
        trdy = 1'b1;
        eds = 1'b1; tick(); eds = 1'b0;
        tick();
        n_tests++;
        if (tvalid !== 1'b1 || tdata !== 64'h0000_0000_55aa_0001 || tlast !== 1'b0 || tkeep !== 8'hFF) begin
            n_fail++;
            $display("FAIL eds_beat0: got valid=%0b data=%h last=%0b keep=%h, need 1 0000000055aa0001 0 ff",
                     tvalid, tdata, tlast, tkeep);
        end
        tick();
        n_tests++;
        if (tvalid !== 1'b1 || tdata !== 64'h1 || tlast !== 1'b1 || tkeep !== 8'hFF) begin
            n_fail++;
            $display("FAIL eds_beat1: got valid=%0b data=%h last=%0b keep=%h, need 1 ..01 1 ff",
                     tvalid, tdata, tlast, tkeep);
        end
        tick();
        n_tests++;
        if (tvalid !== 1'b0 || frame_cnt !== 32'd1 || tkeep !== 8'h00 || tdata !== 64'd0) begin
            n_fail++;
            $display("FAIL eds_after: got valid=%0b frames=%0d keep=%h data=%h, need 0 1 00 0",
                     tvalid, frame_cnt, tkeep, tdata);
        end
    endtask

    task automatic test_link_debounce();
        int bad_valid = 0, bad_link = 0;
        do_reset();
        trdy = 1'b1;
        cu = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            pmt = (c == 10);
            tick();
            if (tvalid !== 1'b0) bad_valid++;
            if (link_ready !== (c >= 16)) bad_link++;
        end
        n_tests++;
        if (bad_valid != 0) begin
            n_fail++;
            $display("FAIL debounce_discard: valid seen in %0d cycles, need 0", bad_valid);
        end
        n_tests++;
        if (bad_link != 0) begin
            n_fail++;
            $display("FAIL debounce_link_ready: %0d cycles wrong, need rise at cycle 16", bad_link);
        end
        pmt = 1'b1; tick(); pmt = 1'b0;
        tick();
        tick();
        n_tests++;
        if (tvalid !== 1'b1 || tdata !== 64'h2 || tlast !== 1'b1) begin
            n_fail++;
            $display("FAIL debounce_pmt_code: got valid=%0b data=%h last=%0b, need 1 ..02 1",
                     tvalid, tdata, tlast);
        end
    endtask

    task automatic test_simultaneous();
        logic [63:0] seen [4];
        do_reset();
        link_up();
        trdy = 1'b1;
        eds = 1'b1; pmt = 1'b1; tick(); eds = 1'b0; pmt = 1'b0;
        tick(); seen[0] = tdata;
        tick(); seen[1] = tdata;
        tick();
        tick(); seen[2] = tdata;
        tick(); seen[3] = tdata;
        tick();
        n_tests++;
        if (seen[0] !== {32'd0, HEAD} || seen[1] !== 64'h1 || seen[2] !== {32'd1, HEAD} ||
            seen[3] !== 64'h2 || frame_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL simultaneous: got %h %h %h %h frames=%0d, need %h 1 %h 2 frames=2",
                     seen[0], seen[1], seen[2], seen[3], frame_cnt, {32'd0, HEAD}, {32'd1, HEAD});
        end
    endtask

    task automatic test_backpressure();
        int hs = 0, drift = 0;
        logic [65:0] snap;
        do_reset();
        link_up();
        trdy = 1'b0;
        eds = 1'b1; tick(); eds = 1'b0;
        tick();
        snap = {tvalid, tlast, tdata};
        n_tests++;
        if (snap !== {1'b1, 1'b0, 32'd0, HEAD}) begin
            n_fail++;
            $display("FAIL bp_head: got %h, need %h", snap, {1'b1, 1'b0, 32'd0, HEAD});
        end
        for (int i = 0; i < 7; i++) begin
            if (tvalid && trdy) hs++;
            tick();
            if ({tvalid, tlast, tdata} !== snap) drift++;
        end
        trdy = 1'b1;
        if (tvalid && trdy) hs++;
        tick();
        trdy = 1'b0;
        snap = {tvalid, tlast, tdata};
        n_tests++;
        if (snap !== {1'b1, 1'b1, 64'h1}) begin
            n_fail++;
            $display("FAIL bp_code: got %h, need %h", snap, {1'b1, 1'b1, 64'h1});
        end
        for (int i = 0; i < 3; i++) begin
            if (tvalid && trdy) hs++;
            tick();
            if ({tvalid, tlast, tdata} !== snap) drift++;
        end
        trdy = 1'b1;
        if (tvalid && trdy) hs++;
        tick();
        n_tests++;
        if (drift != 0 || hs != 2 || frame_cnt !== 32'd1 || tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: got drift=%0d handshakes=%0d frames=%0d valid=%0b, need 0 2 1 0",
                     drift, hs, frame_cnt, tvalid);
        end
    endtask

    task automatic test_merge();
        int lasts = 0;
        do_reset();
        link_up();
        trdy = 1'b0;
        eds = 1'b1; tick(); eds = 1'b0; tick();
        for (int i = 0; i < 3; i++) begin
            eds = 1'b1; tick(); eds = 1'b0; tick();
        end
        n_tests++;
        if (merge_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL merge_count: got %0d, need 2", merge_cnt);
        end
        trdy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (tvalid && tlast && trdy) lasts++;
            tick();
        end
        n_tests++;
        if (lasts != 2 || frame_cnt !== 32'd2 || merge_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL merge_frames: got frames_seen=%0d frames=%0d merges=%0d, need 2 2 2",
                     lasts, frame_cnt, merge_cnt);
        end
    endtask

    task automatic test_link_drop();
        int stray = 0;
        do_reset();
        link_up();
        trdy = 1'b1;
        eds = 1'b1; tick(); eds = 1'b0;
        tick();
        pmt = 1'b1; tick(); pmt = 1'b0;
        trdy = 1'b0;
        tick();
        cu = 1'b0;
        tick();
        n_tests++;
        if (link_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_link_ready: got %0b, need 0", link_ready);
        end
        tick();
        n_tests++;
        if (tvalid !== 1'b0 || frame_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL drop_abort: got valid=%0b frames=%0d, need 0 0", tvalid, frame_cnt);
        end
        trdy = 1'b1;
        cu = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (tvalid !== 1'b0) stray++;
        end
        n_tests++;
        if (stray != 0 || frame_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL drop_flags_cleared: valid in %0d cycles, frames=%0d, need 0 0", stray, frame_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        link_up();
        trdy = 1'b1;
        eds = 1'b1; tick(); eds = 1'b0;
        repeat (4) tick();
        trdy = 1'b0;
        pmt = 1'b1; tick(); pmt = 1'b0;
        tick();
        n_tests++;
        if (tvalid !== 1'b1 || frame_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL areset_setup: got valid=%0b frames=%0d, need 1 1", tvalid, frame_cnt);
        end
        rst = 1'b1;
        #2;
        n_tests++;
        if ({tvalid, tdata, tkeep, tlast, frame_cnt, merge_cnt, link_ready} !== 123'd0) begin
            n_fail++;
            $display("FAIL areset_immediate: got valid=%0b data=%h frames=%0d link=%0b, need all zero",
                     tvalid, tdata, frame_cnt, link_ready);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [63:0] exp_data;
        do_reset();
        cu = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            eds  = ($urandom_range(0, 3) == 0);
            pmt  = ($urandom_range(0, 3) == 0);
            trdy = ($urandom_range(0, 3) != 0);
            if (cu && $urandom_range(0, 299) == 0) cu = 1'b0;
            else if (!cu && $urandom_range(0, 5) == 0) cu = 1'b1;
            tick();
            exp_data = (m_beat == 1) ? {m_frames, HEAD} :
                       (m_beat == 2) ? {56'd0, m_code} : 64'd0;
            n_tests++;
            if (tvalid !== (m_beat != 0) || tdata !== exp_data ||
                tkeep !== ((m_beat != 0) ? 8'hFF : 8'h00) || tlast !== (m_beat == 2) ||
                frame_cnt !== m_frames || merge_cnt !== m_merges[15:0] ||
                link_ready !== (m_up >= 16)) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got v=%0b d=%h k=%h l=%0b f=%0d m=%0d lr=%0b, need v=%0b d=%h l=%0b f=%0d m=%0d lr=%0b",
                         c, tvalid, tdata, tkeep, tlast, frame_cnt, merge_cnt, link_ready,
                         (m_beat != 0), exp_data, (m_beat == 2), m_frames, m_merges, (m_up >= 16));
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_eds_frame();
        test_link_debounce();
        test_simultaneous();
        test_backpressure();
        test_merge();
        test_link_drop();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aurora_64b66b_tx.md
# aurora_64b66b_tx

Transmit-side companion of the Aurora 64B/66B end-event receiver. Turns local EDS-end and PMT-end event strobes into two-beat AXI-Stream frames. The receiver at the far end decodes each frame into `pcie_eds_end_o` or `pcie_pmt_end_o`. The block sits between the timing logic and the Aurora core TX user interface, in the `USER_CLK` domain. It gates transmission on a debounced `CHANNEL_UP`, arbitrates simultaneous events, and holds data stable under backpressure.

## Interface
Parameters:
- `TCQ`, 0.1: register clock-to-q modelling delay.
- `HEAD_WORD`, 32'h55aa_0001: frame header, driven on `tdata[31:0]` of beat 0.
- `EDS_CODE`, 8'd1: end code for EDS, driven on `tdata[7:0]` of beat 1.
- `PMT_CODE`, 8'd2: end code for PMT, driven on `tdata[7:0]` of beat 1.

Ports:
- `USER_CLK`  in  1: sole clock (Aurora user clock).
- `RESET`  in  1: asynchronous, active-high reset.
- `CHANNEL_UP`  in  1: Aurora channel-up status.
- `eds_end_i`  in  1: EDS end event, level or pulse; rising edge = one request.
- `pmt_end_i`  in  1: PMT end event, level or pulse; rising edge = one request.
- `tx_tready_i`  in  1: Aurora TX ready.
- `tx_tvalid_o`  out  1: TX valid.
- `tx_tdata_o`  out  64: TX data.
- `tx_tkeep_o`  out  8: TX byte keep, always 8'hFF while valid.
- `tx_tlast_o`  out  1: TX last, set on beat 1 only.
- `frame_cnt_o`  out  32: number of frames fully transmitted (beat-1 handshakes).
- `merge_cnt_o`  out  16: requests merged into an already-pending request.
- `link_ready_o`  out  1: debounced link-ready flag.

## Operation
**Link qualification**
- A 5-bit counter increments while `CHANNEL_UP`=1 and saturates once bit 4 is set.
- The counter clears to 0 whenever `CHANNEL_UP`=0.
- `link_ready_o` = counter bit 4, so it asserts 16 cycles after `CHANNEL_UP` rises.

**Event capture**
- Each input is registered. A rising edge is (current=1 && previous=0).
- An edge sets pending flag `eds_pend` or `pmt_pend`.
- An edge that arrives while its own flag is already set is merged: the flag stays 1 and `merge_cnt_o` increments, saturating at 16'hFFFF.
- While `link_ready_o`=0, edges are discarded and both flags are held at 0.

**State machine**
- `TX_IDLE`
  - Go to `TX_HEAD` when `link_ready_o` and either flag is set.
  - EDS has priority over PMT. The selected code is latched at this transition, and the selected flag clears in the same cycle.
- `TX_HEAD`
  - `tvalid`=1, `tdata` = {`frame_cnt_o`, `HEAD_WORD`}, `tlast`=0.
  - Go to `TX_CODE` on `tready`.
- `TX_CODE`
  - `tvalid`=1, `tdata` = {56'd0, latched code}, `tlast`=1.
  - On `tready`: increment `frame_cnt_o` (wraps 2^32−1 → 0) and go to `TX_IDLE`.

**Boundary behaviour**
- Outside `TX_HEAD` and `TX_CODE`: `tvalid`=0 and `tdata`=0, `tkeep`=0, `tlast`=0.
- Outputs are held constant while `tvalid`=1 and `tready`=0.
- An edge on an input during its own frame (flag already cleared) sets the flag again and queues a new frame.
- If `link_ready_o` drops in `TX_HEAD` or `TX_CODE`:
  - the FSM goes to `TX_IDLE` on the next edge;
  - `tvalid` deasserts;
  - pending flags clear;
  - `frame_cnt_o` is not incremented.
- Simultaneous EDS and PMT edges: the EDS frame is sent first, then the PMT frame.

## Timing
- Reset values (asynchronous `RESET`):
  - all outputs 0;
  - state `TX_IDLE`, pending flags 0, edge registers 0, link counter 0.
- Latency, with link ready and `tready`=1:
  - input rises before clock edge k, so the edge is detected and the flag set at edge k;
  - `TX_IDLE` → `TX_HEAD` at edge k+1, so `tvalid` is high in cycle k+1;
  - beat 1 in cycle k+2;
  - `frame_cnt_o` updates at edge k+3.
- Frame spacing: at least one idle cycle between frames (`TX_CODE` → `TX_IDLE` → `TX_HEAD`). Minimum period is 3 cycles per frame.
- The AXI handshake completes on any edge with `tvalid` && `tready`. The core may assert `tready` before `tvalid`.

## Test plan
1. **EDS frame.** Reset, `CHANNEL_UP`=1 for 20 cycles, `tready`=1, one `eds_end_i` pulse.
   - Beat 0: `tdata`=64'h0000_0000_55aa_0001, `tlast`=0.
   - Beat 1: `tdata[7:0]`=01, `tlast`=1, `tkeep`=FF.
   - `frame_cnt_o`=1.
2. **Link debounce.** `CHANNEL_UP` rises, and a `pmt_end_i` edge arrives at cycle 10.
   - The edge is discarded and no frame is sent.
   - `link_ready_o` rises at cycle 16.
   - A later PMT edge sends a frame with code 02.
3. **Simultaneous events.** EDS and PMT edges in the same cycle.
   - Two frames: code 01, then code 02.
   - Upper words are 0 then 1.
   - `frame_cnt_o`=2.
4. **Backpressure.** `tready`=0 for 7 cycles during `TX_HEAD`, then for 3 cycles during `TX_CODE`.
   - `tdata`, `tvalid` and `tlast` stay constant throughout.
   - Exactly two handshakes occur.
5. **Merge.** Three EDS edges while the EDS flag is pending (`tready`=0 stall in `TX_HEAD`).
   - `merge_cnt_o`=2 at the end (first edge sets the flag, the next two merge, assuming the third edge is not during that EDS frame).
   - Only one additional frame is queued.
6. **Link drop and reset.** Drop `CHANNEL_UP` during `TX_CODE` with `tready`=0.
   - `tvalid` low the next cycle.
   - `frame_cnt_o` unchanged and flags clear.
   - Asserting `RESET` mid-frame zeroes all outputs immediately, without waiting for a clock edge.
